// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - ChaCha word/state types, constants, FSM encoding and word helpers
package chacha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t       state_t [16];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEYED = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } fsm_t;

    // "expand 32-byte k" and "expand 16-byte k" as little-endian words
    localparam word_t SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
    localparam word_t TAU   [4] = '{32'h61707865, 32'h3120646e, 32'h79622d36, 32'h6b206574};

    // The bus carries bytes big-endian within a word; ChaCha works little-endian
    function automatic word_t bswap(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic word_t rotl(input word_t w, input logic [4:0] n);
        return (w << n) | (w >> (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/chacha_stream_if.sv
// rtl/chacha_stream_if.sv - data-block input and result output handshakes of chacha_stream
interface chacha_stream_if;

    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;

    // Block producer / result consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Cipher core side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/chacha_qr.sv
// rtl/chacha_qr.sv - combinational ChaCha quarter-round on four words
module chacha_qr
    import chacha_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    input  word_t i_c,
    input  word_t i_d,
    output word_t o_a,
    output word_t o_b,
    output word_t o_c,
    output word_t o_d
);

    word_t w_a0, w_b0, w_c0, w_d0;
    word_t w_a1, w_b1, w_c1, w_d1;

    assign w_a0 = i_a + i_b;
    assign w_d0 = rotl(i_d ^ w_a0, 5'd16);
    assign w_c0 = i_c + w_d0;
    assign w_b0 = rotl(i_b ^ w_c0, 5'd12);

    assign w_a1 = w_a0 + w_b0;
    assign w_d1 = rotl(w_d0 ^ w_a1, 5'd8);
    assign w_c1 = w_c0 + w_d1;
    assign w_b1 = rotl(w_b0 ^ w_c1, 5'd7);

    assign o_a = w_a1;
    assign o_b = w_b1;
    assign o_c = w_c1;
    assign o_d = w_d1;

endmodule

// File: rtl/chacha_stream.sv
// rtl/chacha_stream.sv - ChaCha stream cipher core, one half-round per cycle; option macro CHACHA_STREAM_CTR_WRAP_ERR_EN
module chacha_stream
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           init,
    input  logic [255:0]   key,
    input  logic           keylen,
    input  logic [63:0]    iv,
    input  logic [63:0]    ctr,
    chacha_stream_if.slave bus,
    output logic           busy,
    output logic           err
);

    generate
        if (ROUNDS != 8 && ROUNDS != 12 && ROUNDS != 20) begin : g_bad_rounds
            $error("chacha_stream: ROUNDS must be 8, 12 or 20");
        end
    endgenerate

    localparam logic [4:0] LP_LAST = 5'(ROUNDS);

    fsm_t         r_state;
    fsm_t         w_state_nxt;

    logic [255:0] r_key;
    logic         r_keylen;
    logic [63:0]  r_iv;
    logic [63:0]  r_ctr;

    state_t       r_x;
    logic [511:0] r_data;
    logic [4:0]   r_cnt;
    logic [511:0] r_out_data;

    state_t       w_init_state;
    state_t       w_x_nxt;
    logic [511:0] w_final;
    logic         w_accept;
    logic         w_out_hs;
    logic         w_last;
    logic         w_diag;

    word_t        w_qa [4];
    word_t        w_qb [4];
    word_t        w_qc [4];
    word_t        w_qd [4];
    word_t        w_ra [4];
    word_t        w_rb [4];
    word_t        w_rc [4];
    word_t        w_rd [4];

    assign bus.in_ready  = (r_state == ST_KEYED) & ~init & ~err;
    assign bus.out_valid = (r_state == ST_OUT);
    assign bus.out_data  = r_out_data;
    assign busy          = (r_state == ST_ROUND) | (r_state == ST_OUT);

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_out_hs = bus.out_valid & bus.out_ready;
    assign w_last   = (r_cnt == LP_LAST);
    assign w_diag   = r_cnt[0];

    // Initial ChaCha state from the latched key material and the running counter
    always_comb begin
        w_init_state = '{default: '0};
        for (int i = 0; i < 4; i++) begin
            w_init_state[i] = r_keylen ? SIGMA[i] : TAU[i];
        end
        for (int i = 0; i < 8; i++) begin
            // a 128-bit key sits in key[255:128] and is used twice
            w_init_state[4 + i] = r_keylen ? bswap(r_key[255 - 32*i -: 32])
                                           : bswap(r_key[255 - 32*(i & 3) -: 32]);
        end
        w_init_state[12] = r_ctr[31:0];
        w_init_state[13] = r_ctr[63:32];
        w_init_state[14] = bswap(r_iv[63:32]);
        w_init_state[15] = bswap(r_iv[31:0]);
    end

    // Route state words to the quarter-rounds: columns on even cycles, diagonals on odd
    always_comb begin
        for (int q = 0; q < 4; q++) begin
            w_qa[q] = r_x[q];
            w_qb[q] = w_diag ? r_x[4 + ((q + 1) & 3)]  : r_x[4 + q];
            w_qc[q] = w_diag ? r_x[8 + ((q + 2) & 3)]  : r_x[8 + q];
            w_qd[q] = w_diag ? r_x[12 + ((q + 3) & 3)] : r_x[12 + q];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        chacha_qr u_qr (
            .i_a (w_qa[g]),
            .i_b (w_qb[g]),
            .i_c (w_qc[g]),
            .i_d (w_qd[g]),
            .o_a (w_ra[g]),
            .o_b (w_rb[g]),
            .o_c (w_rc[g]),
            .o_d (w_rd[g])
        );
    end

    // Scatter quarter-round results back into their state positions
    always_comb begin
        w_x_nxt = r_x;
        for (int q = 0; q < 4; q++) begin
            w_x_nxt[q] = w_ra[q];
            if (w_diag) begin
                w_x_nxt[4 + ((q + 1) & 3)]  = w_rb[q];
                w_x_nxt[8 + ((q + 2) & 3)]  = w_rc[q];
                w_x_nxt[12 + ((q + 3) & 3)] = w_rd[q];
            end else begin
                w_x_nxt[4 + q]  = w_rb[q];
                w_x_nxt[8 + q]  = w_rc[q];
                w_x_nxt[12 + q] = w_rd[q];
            end
        end
    end

    // Feed-forward add, byte order back to bus order, XOR with the latched block
    always_comb begin
        w_final = '0;
        for (int i = 0; i < 16; i++) begin
            w_final[511 - 32*i -: 32] = bswap(r_x[i] + w_init_state[i]) ^ r_data[511 - 32*i -: 32];
        end
    end

    // FSM next state; init overrides everything and aborts any block in flight
    always_comb begin
        w_state_nxt = r_state;
        if (init) begin
            w_state_nxt = ST_KEYED;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_IDLE;
                ST_KEYED: if (w_accept) w_state_nxt = ST_ROUND;
                ST_ROUND: if (w_last) w_state_nxt = ST_OUT;
                ST_OUT:   if (bus.out_ready) w_state_nxt = ST_KEYED;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Key material and block counter; the counter advances only when a result is taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key    <= '0;
            r_keylen <= 1'b0;
            r_iv     <= '0;
            r_ctr    <= '0;
        end else if (init) begin
            r_key    <= key;
            r_keylen <= keylen;
            r_iv     <= iv;
            r_ctr    <= ctr;
        end else if (w_out_hs) begin
            r_ctr <= r_ctr + 64'd1;
        end
    end

    // Round state: load on accept, one half-round per cycle, hold while finalising
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x    <= '{default: '0};
            r_data <= '0;
            r_cnt  <= '0;
        end else if (!init) begin
            if (w_accept) begin
                r_x    <= w_init_state;
                r_data <= bus.in_data;
                r_cnt  <= '0;
            end else if (r_state == ST_ROUND && !w_last) begin
                r_x   <= w_x_nxt;
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Result register, written on the cycle after the last half-round
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data <= '0;
        end else if (!init && r_state == ST_ROUND && w_last) begin
            r_out_data <= w_final;
        end
    end

`ifdef CHACHA_STREAM_CTR_WRAP_ERR_EN
    logic r_err;

    // Sticky once the block that used the last counter value has been handed off
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (init) begin
            r_err <= 1'b0;
        end else if (w_out_hs && (&r_ctr)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_chacha_stream.sv
// tb/tb_chacha_stream.sv - self-checking bench for chacha_stream
module tb_chacha_stream;

    localparam int ROUNDS = 20;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         init;
    logic [255:0] key;
    logic         keylen;
    logic [63:0]  iv;
    logic [63:0]  ctr;
    logic         busy;
    logic         err;

    chacha_stream_if bus();

    chacha_stream #(.ROUNDS(ROUNDS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (init),
        .key     (key),
        .keylen  (keylen),
        .iv      (iv),
        .ctr     (ctr),
        .bus     (bus),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    logic [511:0] exp_q [$];

    typedef struct {
        logic [255:0] key;
        logic         kl;
        logic [63:0]  iv;
        logic [63:0]  ctr;
        logic [511:0] din;
        logic [511:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] bs(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    function automatic logic [511:0] model(input logic [255:0] k, input logic kl, input logic [63:0] v,
                                           input logic [63:0] c, input logic [511:0] d);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [511:0] r;
        int qi [8][4];
        qi = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
               '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        s[0] = 32'h61707865;
        s[1] = kl ? 32'h3320646e : 32'h3120646e;
        s[2] = kl ? 32'h79622d32 : 32'h79622d36;
        s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            if (kl) s[4+i] = bs(k[255 - 32*i -: 32]);
            else    s[4+i] = bs(k[255 - 32*(i % 4) -: 32]);
        end
        s[12] = c[31:0];
        s[13] = c[63:32];
        s[14] = bs(v[63:32]);
        s[15] = bs(v[31:0]);
        x = s;
        for (int h = 0; h < ROUNDS; h++) begin
            for (int q = 0; q < 4; q++) begin
                int a, b, cc, dd;
                a  = qi[(h % 2)*4 + q][0];
                b  = qi[(h % 2)*4 + q][1];
                cc = qi[(h % 2)*4 + q][2];
                dd = qi[(h % 2)*4 + q][3];
                x[a]  = x[a] + x[b];   x[dd] = rl(x[dd] ^ x[a], 16);
                x[cc] = x[cc] + x[dd]; x[b]  = rl(x[b] ^ x[cc], 12);
                x[a]  = x[a] + x[b];   x[dd] = rl(x[dd] ^ x[a], 8);
                x[cc] = x[cc] + x[dd]; x[b]  = rl(x[b] ^ x[cc], 7);
            end
        end
        for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = bs(x[i] + s[i]) ^ d[511 - 32*i -: 32];
        return r;
    endfunction

    task automatic do_init(input logic [255:0] k, input logic kl, input logic [63:0] v, input logic [63:0] c);
        @(negedge clk);
        init = 1'b1; key = k; keylen = kl; iv = v; ctr = c;
        @(negedge clk);
        init = 1'b0;
        #1;
    endtask

    task automatic send_blk(input logic [511:0] d, output int acc);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        chk("in_ready_before_send", {511'd0, bus.in_ready}, 512'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        acc = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("busy_in_round", {511'd0, busy}, 512'd1);
        chk("in_ready_low_in_round", {511'd0, bus.in_ready}, 512'd0);
    endtask

    task automatic rx_blk(input int acc, input int hold, output logic [511:0] got);
        int n = 0;
        logic [511:0] e;
        while (bus.out_valid !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
        chk("out_valid_seen", {511'd0, bus.out_valid}, 512'd1);
        chk("latency", 512'(cyc - acc), 512'(ROUNDS + 1));
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        got = bus.out_data;
        chk("out_data", got, e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk("hold_valid", {511'd0, bus.out_valid}, 512'd1);
            chk("hold_data", bus.out_data, e);
            chk("hold_in_ready_low", {511'd0, bus.in_ready}, 512'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk("busy_after_ack", {511'd0, busy}, 512'd0);
    endtask

    task automatic xfer(input logic [511:0] d, input logic [511:0] exp, input int hold, output logic [511:0] got);
        int acc;
        exp_q.push_back(exp);
        send_blk(d, acc);
        rx_blk(acc, hold, got);
    endtask

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [63:0]  V1 = 64'h0000004a00000000;

    initial begin
        vec_t vt [4];
        logic [511:0] got, ct, pt;
        int acc, seen;

        reset_n = 1'b0; init = 1'b0; key = '0; keylen = 1'b0; iv = '0; ctr = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

        vt[0] = '{K1, 1'b1, V1, 64'd1, {16{32'h00000000}}, '0};
        vt[1] = '{256'h80000000_00000000_00000000_00000000_11223344_55667788_99aabbcc_ddeeff00,
                  1'b0, 64'h0102030405060708, 64'h0000000100000002, {8{64'h0123456789abcdef}}, '0};
        vt[2] = '{{8{32'hc0ffee11}}, 1'b1, 64'hffffffff00000000, 64'h00000000ffffffff, {16{32'h5a5aa5a5}}, '0};
        vt[3] = '{~K1, 1'b0, 64'h00000000ffffffff, 64'h1234567800000000, {K1, ~K1}, '0};
        for (int i = 0; i < 4; i++) vt[i].exp = model(vt[i].key, vt[i].kl, vt[i].iv, vt[i].ctr, vt[i].din);

        // reset state
        #1;
        chk("rst_out_valid", {511'd0, bus.out_valid}, 512'd0);
        chk("rst_out_data", bus.out_data, 512'd0);
        chk("rst_busy", {511'd0, busy}, 512'd0);
        chk("rst_err", {511'd0, err}, 512'd0);
        chk("rst_in_ready", {511'd0, bus.in_ready}, 512'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // no block accepted before init
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("idle_in_ready_low", {511'd0, bus.in_ready}, 512'd0);
            chk("idle_not_busy", {511'd0, busy}, 512'd0);
        end
        bus.in_valid = 1'b0;

        // zero vector
        do_init('0, 1'b1, '0, '0);
        xfer('0, model('0, 1'b1, '0, '0, '0), 0, got);
        chk("zero_vec_ks", {448'd0, got[511:448]}, {448'd0, 64'h76b8e0ada0f13d90});

        // table vectors
        for (int i = 0; i < 4; i++) begin
            do_init(vt[i].key, vt[i].kl, vt[i].iv, vt[i].ctr);
            xfer(vt[i].din, vt[i].exp, 0, got);
        end

        // streaming with a stalled consumer on block 1
        do_init(K1, 1'b1, V1, 64'd0);
        xfer({16{32'h11111111}}, model(K1, 1'b1, V1, 64'd0, {16{32'h11111111}}), 5, got);
        xfer({16{32'h22222222}}, model(K1, 1'b1, V1, 64'd1, {16{32'h22222222}}), 0, got);
        xfer({16{32'h33333333}}, model(K1, 1'b1, V1, 64'd2, {16{32'h33333333}}), 0, got);
        do_init(K1, 1'b1, V1, 64'd1);
        xfer({16{32'h22222222}}, model(K1, 1'b1, V1, 64'd1, {16{32'h22222222}}), 0, got);

        // round trip
        pt = {16{32'hdeadbeef}};
        do_init(K1, 1'b0, V1, 64'd7);
        xfer(pt, model(K1, 1'b0, V1, 64'd7, pt), 0, ct);
        do_init(K1, 1'b0, V1, 64'd7);
        xfer(ct, pt, 0, got);

        // counter end
        do_init(K1, 1'b1, V1, '1);
        xfer(pt, model(K1, 1'b1, V1, '1, pt), 0, got);
`ifdef CHACHA_STREAM_CTR_WRAP_ERR_EN
        chk("ctr_end_err_set", {511'd0, err}, 512'd1);
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("ctr_end_in_ready_low", {511'd0, bus.in_ready}, 512'd0);
            chk("ctr_end_not_busy", {511'd0, busy}, 512'd0);
        end
        bus.in_valid = 1'b0;
        do_init(K1, 1'b1, V1, 64'd0);
        chk("ctr_end_err_cleared", {511'd0, err}, 512'd0);
        chk("ctr_end_ready_again", {511'd0, bus.in_ready}, 512'd1);
`else
        chk("ctr_end_err_zero", {511'd0, err}, 512'd0);
        xfer(pt, model(K1, 1'b1, V1, 64'd0, pt), 0, got);
`endif

        // abort with init on the 5th ROUND cycle
        do_init(K1, 1'b1, V1, 64'd5);
        send_blk({16{32'h0badf00d}}, acc);
        repeat (4) @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        #1;
        chk("abort_in_ready", {511'd0, bus.in_ready}, 512'd1);
        chk("abort_not_busy", {511'd0, busy}, 512'd0);
        seen = 0;
        repeat (30) begin
            if (bus.out_valid === 1'b1) seen++;
            @(negedge clk); #1;
        end
        chk("abort_no_valid", 512'(seen), 512'd0);
        xfer({16{32'h0badf00d}}, model(K1, 1'b1, V1, 64'd5, {16{32'h0badf00d}}), 0, got);

        // asynchronous reset while a result is waiting
        do_init(K1, 1'b1, V1, 64'd9);
        send_blk(pt, acc);
        seen = 0;
        while (bus.out_valid !== 1'b1 && seen < 100) begin @(negedge clk); #1; seen++; end
        chk("rst_pre_valid", {511'd0, bus.out_valid}, 512'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", {511'd0, bus.out_valid}, 512'd0);
        chk("arst_out_data", bus.out_data, 512'd0);
        chk("arst_busy", {511'd0, busy}, 512'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("post_rst_in_ready_low", {511'd0, bus.in_ready}, 512'd0);
        end
        bus.in_valid = 1'b0;
        do_init(K1, 1'b1, V1, 64'd9);
        chk("post_rst_init_ready", {511'd0, bus.in_ready}, 512'd1);
        xfer(pt, model(K1, 1'b1, V1, 64'd9, pt), 0, got);

        chk("scoreboard_empty", 512'(exp_q.size()), 512'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/chacha_stream.md
CHACHA_STREAM -- requirements
Module: chacha_stream

Interface
REQ-001 SHALL have parameter ROUNDS, default 20, number of ChaCha rounds; legal values 8, 12, 20; other values are an elaboration error.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port init  input  1  single-cycle pulse that loads key, keylen, iv and ctr.
REQ-005 SHALL have port key  input  256  key; 128-bit keys are taken from key[255:128].
REQ-006 SHALL have port keylen  input  1  key length: 0 = 128-bit (tau constant), 1 = 256-bit (sigma constant).
REQ-007 SHALL have port iv  input  64  nonce.
REQ-008 SHALL have port ctr  input  64  initial block counter.
REQ-009 SHALL have port in_valid / in_ready  input / output  1 / 1  data-block handshake.
REQ-010 SHALL have port in_data  input  512  plaintext block.
REQ-011 SHALL have port out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-012 SHALL have port out_data  output  512  in_data XOR keystream.
REQ-013 SHALL have port busy  output  1  high in ROUND and OUT.
REQ-014 SHALL have port err  output  1  sticky counter-exhausted flag (see REQ-030).

Function
REQ-015 SHALL implement FSM states IDLE, KEYED, ROUND, OUT.
REQ-016 SHALL latch key, keylen, iv and ctr on init in any state, abort any in-flight block (out_valid low next cycle), and go to KEYED.
REQ-017 SHALL drive in_ready = (state==KEYED) & ~init & ~err; init wins over a simultaneous in_valid.
REQ-018 SHALL, on in_valid&in_ready, latch in_data, build the initial state and enter ROUND:
- words 0-3: constant
- words 4-11: key words key[255:224]..key[31:0], each byte-swapped
- words 12/13: ctr[31:0] / ctr[63:32]
- words 14/15: byte-swapped iv[63:32] / iv[31:0]
REQ-019 SHALL perform exactly one half-round per ROUND cycle using four parallel quarter-rounds: column rounds on even cycles, diagonal rounds on odd cycles.
REQ-020 SHALL, on the edge after the ROUNDS-th half-round, add the initial state word-wise mod 2^32, byte-swap each word, XOR with the latched data, register the result into out_data (word 0 at [511:480]), and assert out_valid.
REQ-021 SHALL assert out_valid exactly ROUNDS+1 cycles after the input handshake edge.
REQ-022 SHALL hold out_data and out_valid stable until out_ready; on out_valid&out_ready, increment the internal counter by 1 (mod 2^64) and return to KEYED.
REQ-023 SHALL carry internal counter state across blocks; only init reloads it.
REQ-024 SHALL keep in_ready low throughout ROUND and OUT; no overlap between blocks.

Reset
REQ-025 SHALL, when reset_n is low, immediately enter IDLE and clear out_valid, busy, err, out_data, the counter, the key registers and the round state.
REQ-026 SHALL drive in_ready low in IDLE; a block is accepted only after an init.

Configuration
REQ-027 SHALL support macro CHACHA_STREAM_CTR_WRAP_ERR_EN.
REQ-028 Without CHACHA_STREAM_CTR_WRAP_ERR_EN: the counter wraps 2^64-1 -> 0 silently and err is tied 0.
REQ-029 With CHACHA_STREAM_CTR_WRAP_ERR_EN: err sets on the output handshake of the block that used counter 2^64-1.
REQ-030 With CHACHA_STREAM_CTR_WRAP_ERR_EN: while err=1, in_ready stays low; only init or reset clears err.

Structure
REQ-031 SHALL take from package chacha_pkg:
- SIGMA and TAU constant words
- 32-bit word typedef
- 16-word state typedef
- FSM state enum
REQ-032 SHALL instantiate combinational sub-module chacha_qr (one quarter-round, four words in and out) four times.

Verification
REQ-033 SHALL test zero vector: ROUNDS=20, key=0, keylen=1, iv=0, ctr=0, in_data=0 -> out_data[511:448]=64'h76b8e0ada0f13d90; out_valid exactly 21 cycles after accept.
REQ-034 SHALL test streaming: 3 back-to-back blocks with out_ready low 5 cycles on block 1 -> out_data stable while waiting; block 2 output equals block 1 output of a fresh init with ctr=1.
REQ-035 SHALL test round trip: encrypt in_data={16{32'hdeadbeef}}, re-init with identical key/iv/ctr, encrypt the ciphertext -> original data returned.
REQ-036 SHALL test counter end: ctr=64'hFFFFFFFFFFFFFFFF, two blocks:
- macro defined: err=1 after block 1, in_ready low
- macro undefined: block 2 equals block 1 output of a fresh init with ctr=0
REQ-037 SHALL test abort: init on the 5th ROUND cycle -> out_valid never asserts for that block; in_ready high next cycle.
REQ-038 SHALL test reset: reset_n low while out_valid=1 -> out_valid=0 and out_data=0 without a clock edge; in_ready=0 until init.
